// File: rtl/wb_trace_buffer.sv
// Writeback commit tracer: records qualifying register writes into a circular buffer.
// Captures one cycle after the commit; readout is show-ahead valid/ready and enabled only in DONE.
module wb_trace_buffer #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 16,
    parameter int SKIP_X0    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wb_valid,
    input  logic [XLEN-1:0]         wb_pc,
    input  logic [REG_ADDR_W-1:0]   wb_rd,
    input  logic [XLEN-1:0]         wb_data,
    input  logic                    cfg_wrap,
    input  logic                    cfg_trig_en,
    input  logic [XLEN-1:0]         cfg_trig_pc,
    input  logic                    arm,
    input  logic                    stop,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [XLEN-1:0]         rd_pc,
    output logic [REG_ADDR_W-1:0]   rd_rd,
    output logic [XLEN-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic [1:0]              state
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_TRIG = 2'd1,
        S_CAPTURE   = 2'd2,
        S_DONE      = 2'd3
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } entry_t;

    entry_t             mem [DEPTH];
    entry_t             wr_ent;
    entry_t             head_ent;
    state_e             state_q, state_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               wr_en;
    logic               qual;
    logic               full;
    logic               do_arm;
    logic               pop;

    assign qual     = wb_valid && !((SKIP_X0 != 0) && (wb_rd == '0));
    assign full     = (count_q == CNT_FULL);
    assign do_arm   = arm && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign rd_valid = (state_q == S_DONE) && (count_q != '0);
    assign pop      = rd_valid && rd_ready;
    assign wr_ent   = '{pc: wb_pc, rd: wb_rd, data: wb_data};

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;
        // arm outranks everything, including a pop in the same cycle
        if (do_arm) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            state_d    = cfg_trig_en ? S_WAIT_TRIG : S_CAPTURE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (stop) state_d = S_DONE;
                end
                S_WAIT_TRIG: begin
                    if (qual && (wb_pc == cfg_trig_pc)) begin
                        wr_en   = 1'b1;
                        tail_d  = tail_q + PTR_ONE;
                        count_d = count_q + CNT_ONE;
                        state_d = stop ? S_DONE : S_CAPTURE;
                    end else if (stop) begin
                        state_d = S_DONE;
                    end
                end
                S_CAPTURE: begin
                    if (qual && !full) begin
                        wr_en   = 1'b1;
                        tail_d  = tail_q + PTR_ONE;
                        count_d = count_q + CNT_ONE;
                        if (!cfg_wrap && (count_q == CNT_FULL - CNT_ONE)) state_d = S_DONE;
                    end else if (qual && cfg_wrap) begin
                        // full in wrap mode: overwrite oldest, head chases tail
                        wr_en      = 1'b1;
                        tail_d     = tail_q + PTR_ONE;
                        head_d     = head_q + PTR_ONE;
                        overflow_d = 1'b1;
                    end
                    if (stop) state_d = S_DONE;
                end
                S_DONE: begin
                    if (pop) begin
                        head_d  = head_q + PTR_ONE;
                        count_d = count_q - CNT_ONE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[tail_q] <= wr_ent;
    end

    assign head_ent = mem[head_q];
    assign rd_pc    = rd_valid ? head_ent.pc   : '0;
    assign rd_rd    = rd_valid ? head_ent.rd   : '0;
    assign rd_data  = rd_valid ? head_ent.data : '0;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign state    = state_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Bench for wb_trace_buffer: queue-based reference model feeds a scoreboard; a negedge monitor compares.
module tb_wb_trace_buffer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_valid = 1'b0;
    logic [31:0] wb_pc = '0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        cfg_wrap = 1'b0;
    logic        cfg_trig_en = 1'b0;
    logic [31:0] cfg_trig_pc = '0;
    logic        arm = 1'b0;
    logic        stop = 1'b0;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [31:0] rd_pc;
    logic [4:0]  rd_rd;
    logic [31:0] rd_data;
    logic [2:0]  count;
    logic        overflow;
    logic [1:0]  state;

    wb_trace_buffer #(.XLEN(32), .REG_ADDR_W(5), .DEPTH(DEPTH), .SKIP_X0(1)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_rd(wb_rd), .wb_data(wb_data),
        .cfg_wrap(cfg_wrap), .cfg_trig_en(cfg_trig_en), .cfg_trig_pc(cfg_trig_pc),
        .arm(arm), .stop(stop),
        .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_pc(rd_pc), .rd_rd(rd_rd), .rd_data(rd_data),
        .count(count), .overflow(overflow), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    // model: the buffer is simply the ordered list of entries the consumer should see
    ent_t        exp_q[$];
    int          mstate = 0;
    bit          movf = 1'b0;
    logic [31:0] got_pc[$];
    logic [4:0]  got_rd[$];
    int          checks = 0;
    int          failures = 0;
    ent_t        mon_e;
    bit          mon_erv;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit   q;
        ent_t e;
        q = wb_valid && (wb_rd != 5'd0);
        e = '{pc: wb_pc, rd: wb_rd, data: wb_data};
        if (arm && (mstate == 0 || mstate == 3)) begin
            exp_q.delete();
            movf   = 1'b0;
            mstate = cfg_trig_en ? 1 : 2;
        end else begin
            case (mstate)
                0: if (stop) mstate = 3;
                1: begin
                    if (q && wb_pc == cfg_trig_pc) begin
                        exp_q.push_back(e);
                        mstate = stop ? 3 : 2;
                    end else if (stop) begin
                        mstate = 3;
                    end
                end
                2: begin
                    if (q) begin
                        if (exp_q.size() < DEPTH) begin
                            exp_q.push_back(e);
                            if (!cfg_wrap && exp_q.size() == DEPTH) mstate = 3;
                        end else if (cfg_wrap) begin
                            void'(exp_q.pop_front());
                            exp_q.push_back(e);
                            movf = 1'b1;
                        end
                    end
                    if (stop) mstate = 3;
                end
                default: ;
            endcase
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_q.delete();
            mstate = 0;
            movf   = 1'b0;
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        mon_erv = (mstate == 3) && (exp_q.size() != 0);
        chk("mon_state", 64'(state), 64'(mstate));
        chk("mon_count", 64'(count), 64'(exp_q.size()));
        chk("mon_overflow", 64'(overflow), 64'(movf));
        chk("mon_rd_valid", 64'(rd_valid), 64'(mon_erv));
        if (rd_valid && rd_ready && !arm) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL mon_pop: DUT popped pc %0h but no entry expected", rd_pc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("mon_pc", 64'(rd_pc), 64'(mon_e.pc));
                chk("mon_rd", 64'(rd_rd), 64'(mon_e.rd));
                chk("mon_data", 64'(rd_data), 64'(mon_e.data));
                got_pc.push_back(rd_pc);
                got_rd.push_back(rd_rd);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] d);
        wb_valid = 1'b1; wb_pc = pc; wb_rd = rd; wb_data = d;
        step();
        wb_valid = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1; step(); arm = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; step(); stop = 1'b0;
    endtask

    task automatic drain(input bit random_ready);
        for (int i = 0; i < 200 && count != 0; i++) begin
            rd_ready = random_ready ? 1'($urandom % 2) : 1'b1;
            step();
        end
        rd_ready = 1'b0;
        if (count != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: count %0d still nonzero", count);
        end
        chk("drain_rd_valid", 64'(rd_valid), 64'd0);
    endtask

    task automatic run_fill();
        cfg_wrap = 1'b0; cfg_trig_en = 1'b0;
        pulse_arm();
        for (int i = 0; i < 6; i++) begin
            send(32'(i * 4), 5'(i + 1), 32'(32'hA0 + i));
            if (i == 3) begin
                chk("fill_state_done", 64'(state), 64'd3);
                chk("fill_count", 64'(count), 64'd4);
                chk("fill_overflow", 64'(overflow), 64'd0);
            end
        end
        got_pc.delete();
        drain(1'b0);
        chk("fill_npop", 64'(got_pc.size()), 64'd4);
        for (int i = 0; i < got_pc.size(); i++) chk("fill_pop_pc", 64'(got_pc[i]), 64'(i * 4));
    endtask

    initial begin
        int n;
        #2;
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_pc", 64'(rd_pc), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        #10 rst = 1'b1;
        step();

        run_fill();

        cfg_wrap = 1'b1;
        pulse_arm();
        for (int i = 0; i < 6; i++) send(32'(i * 4), 5'(i + 1), 32'(32'hA0 + i));
        pulse_stop();
        chk("wrap_count", 64'(count), 64'd4);
        chk("wrap_overflow", 64'(overflow), 64'd1);
        got_pc.delete();
        drain(1'b0);
        chk("wrap_npop", 64'(got_pc.size()), 64'd4);
        for (int i = 0; i < got_pc.size(); i++) chk("wrap_pop_pc", 64'(got_pc[i]), 64'(8 + i * 4));
        cfg_wrap = 1'b0;

        cfg_trig_en = 1'b1; cfg_trig_pc = 32'h0C;
        pulse_arm();
        chk("trig_wait_state", 64'(state), 64'd1);
        for (int i = 0; i < 6; i++) send(32'(i * 4), 5'(i + 1), 32'(i));
        pulse_stop();
        chk("trig_count", 64'(count), 64'd3);
        got_pc.delete();
        drain(1'b0);
        chk("trig_npop", 64'(got_pc.size()), 64'd3);
        for (int i = 0; i < got_pc.size(); i++) chk("trig_pop_pc", 64'(got_pc[i]), 64'(12 + i * 4));
        cfg_trig_en = 1'b0;

        pulse_arm();
        send(32'h100, 5'd0, 32'h1);
        send(32'h104, 5'd5, 32'h2);
        send(32'h108, 5'd0, 32'h3);
        send(32'h10C, 5'd7, 32'h4);
        pulse_stop();
        chk("x0_count", 64'(count), 64'd2);
        got_rd.delete();
        drain(1'b0);
        chk("x0_npop", 64'(got_rd.size()), 64'd2);
        if (got_rd.size() == 2) begin
            chk("x0_rd0", 64'(got_rd[0]), 64'd5);
            chk("x0_rd1", 64'(got_rd[1]), 64'd7);
        end

        pulse_arm();
        for (int i = 0; i < 3; i++) send(32'(i * 4), 5'(i + 1), 32'(i));
        chk("pre_rst_count", 64'(count), 64'd3);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_state", 64'(state), 64'd0);
        chk("async_rst_count", 64'(count), 64'd0);
        chk("async_rst_rd_valid", 64'(rd_valid), 64'd0);
        #4 rst = 1'b1;
        step();
        run_fill();

        pulse_arm();
        send(32'h40, 5'd1, 32'h1);
        send(32'h44, 5'd2, 32'h2);
        pulse_stop();
        chk("sim_done_state", 64'(state), 64'd3);
        chk("sim_done_count", 64'(count), 64'd2);
        n = got_pc.size();
        arm = 1'b1; rd_ready = 1'b1;
        step();
        arm = 1'b0; rd_ready = 1'b0;
        chk("sim_arm_count", 64'(count), 64'd0);
        chk("sim_arm_state", 64'(state), 64'd2);
        chk("sim_arm_nopop", 64'(got_pc.size()), 64'(n));
        send(32'h50, 5'd3, 32'h3);
        wb_valid = 1'b1; wb_pc = 32'h54; wb_rd = 5'd4; wb_data = 32'h4; stop = 1'b1;
        step();
        wb_valid = 1'b0; stop = 1'b0;
        chk("sim_stop_count", 64'(count), 64'd2);
        chk("sim_stop_state", 64'(state), 64'd3);
        drain(1'b0);

        for (int r = 0; r < 30; r++) begin
            cfg_wrap    = 1'($urandom % 2);
            cfg_trig_en = 1'($urandom % 2);
            cfg_trig_pc = 32'(($urandom % 8) * 4);
            pulse_arm();
            for (int c = 0; c < 12 + int'($urandom % 12); c++) begin
                wb_valid = ($urandom % 4) != 0;
                wb_pc    = 32'(($urandom % 8) * 4);
                wb_rd    = ($urandom % 3 == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                wb_data  = $urandom;
                stop     = ($urandom % 16) == 0;
                arm      = ($urandom % 8) == 0;
                rd_ready = 1'($urandom % 2);
                step();
            end
            wb_valid = 1'b0; arm = 1'b0; stop = 1'b0; rd_ready = 1'b0;
            pulse_stop();
            drain(1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        failures++;
        $display("FAIL global_timeout: simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/wb_trace_buffer.md
Name: wb_trace_buffer

Overview:
- Parametrised writeback commit tracer that sits beside the CPU top level.
- Observes the writeback-stage register-write port (valid, pc, rd, data) and records qualifying commits into a DEPTH-entry circular buffer.
- Supports PC-match triggering and fill-stop or wrap capture modes.
- Captured entries are drained through a valid/ready readout port, giving synthesizable, on-chip visibility of the commit stream.

Parameters:
- XLEN, 32, width of pc and write data.
- REG_ADDR_W, 5, width of destination register index.
- DEPTH, 16, buffer entries; must be a power of 2, minimum 2.
- SKIP_X0, 1, when 1, writes to register 0 are not recorded.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset; asynchronous, active-low (asserted when 0).
- wb_valid  in  1  writeback register-write strobe.
- wb_pc  in  XLEN  pc of the committing instruction.
- wb_rd  in  REG_ADDR_W  destination register.
- wb_data  in  XLEN  write-back data.
- cfg_wrap  in  1  0 = fill-stop mode, 1 = wrap mode.
- cfg_trig_en  in  1  1 = wait for PC trigger before capturing.
- cfg_trig_pc  in  XLEN  trigger pc.
- arm  in  1  single-cycle start pulse.
- stop  in  1  single-cycle stop pulse.
- rd_valid  out  1  oldest entry available.
- rd_ready  in  1  consumer accepts entry.
- rd_pc  out  XLEN  oldest entry pc.
- rd_rd  out  REG_ADDR_W  oldest entry rd.
- rd_data  out  XLEN  oldest entry data.
- count  out  log2(DEPTH)+1  entries held.
- overflow  out  1  sticky flag: at least one entry was overwritten.
- state  out  2  0 = IDLE, 1 = WAIT_TRIG, 2 = CAPTURE, 3 = DONE.

Behaviour:
- **Reset (rst = 0, asynchronous):**
  - state = IDLE; head, tail, count = 0; overflow = 0.
  - rd_valid = 0; rd_pc, rd_rd, rd_data read as 0.
  - Buffer RAM contents are not reset.
  - Reset taking effect mid-capture or mid-readout discards all entries.
- **Qualifying event:** wb_valid = 1, and not (SKIP_X0 = 1 and wb_rd = 0).
- **Write timing:** an accepted event is written at the rising edge. count, tail and rd_valid reflect it from the next cycle (1-cycle latency).
- **IDLE:**
  - arm → WAIT_TRIG if cfg_trig_en, else CAPTURE.
  - arm clears head, tail, count and overflow in the same edge.
  - stop → DONE.
- **WAIT_TRIG:**
  - A qualifying event with wb_pc == cfg_trig_pc is recorded as entry 0; state → CAPTURE.
  - Non-matching events are ignored.
  - stop → DONE with count = 0.
  - If stop and a trigger event occur in the same cycle, the event is recorded and state → DONE.
- **CAPTURE, fill-stop mode (cfg_wrap = 0):**
  - Each qualifying event is appended.
  - The write that makes count = DEPTH also moves state → DONE; later events are dropped.
- **CAPTURE, wrap mode (cfg_wrap = 1):**
  - When count = DEPTH, the event overwrites the oldest entry; head advances with tail.
  - count stays at DEPTH; overflow sets to 1 and stays set.
  - State remains CAPTURE until stop.
- **stop during CAPTURE:** state → DONE. An event in the same cycle is still recorded.
- **cfg_* sampling:** sampled live; must be held stable from arm until DONE.
- **DONE / readout:**
  - rd_valid = (count != 0). rd_pc, rd_rd, rd_data present the head entry combinationally (show-ahead).
  - rd_valid & rd_ready pops the head: head+1, count−1.
  - Pointers wrap modulo DEPTH.
  - Popping the last entry sets rd_valid = 0; state stays DONE.
- **Readout gating:** rd_valid = 0 in every state except DONE; rd_ready is ignored there.
- **arm in DONE:** discards remaining entries, clears overflow, and rearms exactly as from IDLE. arm takes priority over a simultaneous pop.
- **arm in WAIT_TRIG or CAPTURE:** ignored.
- **Pointer width:** pointers are log2(DEPTH) bits. count is one bit wider so that count = DEPTH is distinguishable from empty.

Test Plan:
1. **Fill-stop capture and drain:**
   - Stimulus: DEPTH = 4, cfg_wrap = 0, cfg_trig_en = 0. Arm, then 6 events with pc 0x00, 0x04, ..., 0x14, rd = 1..6, data = 0xA0..0xA5.
   - Required: state = DONE after the 4th event; count = 4; overflow = 0. With rd_ready held 1, pops return pc 0x00, 0x04, 0x08, 0x0C in order, then rd_valid = 0.
2. **Wrap mode:**
   - Stimulus: DEPTH = 4, cfg_wrap = 1. Arm, send the same 6 events, then stop.
   - Required: count = 4, overflow = 1. Drain returns pc 0x08, 0x0C, 0x10, 0x14.
3. **PC trigger:**
   - Stimulus: cfg_trig_en = 1, cfg_trig_pc = 0x0C. Send events at pc 0x00..0x14 in steps of 4, then stop.
   - Required: first entry pc = 0x0C; count = 3 (0x0C, 0x10, 0x14).
4. **x0 filtering:**
   - Stimulus: SKIP_X0 = 1. Send events with rd = 0, 5, 0, 7, then stop.
   - Required: count = 2; entries have rd = 5 and rd = 7.
5. **Asynchronous reset mid-capture:**
   - Stimulus: after 3 captured events, drive rst = 0 between clock edges.
   - Required: state = 0, count = 0, rd_valid = 0 immediately, without waiting for a clock edge. Following rearm, capture behaves as in scenario 1.
6. **Simultaneous events:**
   - Stimulus: in DONE with count = 2, assert arm and rd_ready together. Separately, in CAPTURE, assert stop together with an event.
   - Required: in the first case the buffer is cleared with no pop observed. In the second case the event is recorded (count + 1) and state = DONE.
